// File: rtl/seqdiv_frac.sv
// rtl/seqdiv_frac.sv - restoring shift-subtract fractional divider, Q_out = floor(2^QW * count / dsor)
module seqdiv_frac #(
  parameter int DW = 19,
  parameter int QW = 8
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          sample,
  input  logic [DW-1:0] count,
  input  logic [DW-1:0] dsor,
  output logic [QW-1:0] Q_out,
  output logic          done
);

  // Bit counter walks 0..QW-1; the conversion finishes on the edge where it reads QW-1.
  localparam int CW = (QW > 1) ? $clog2(QW) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(QW - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_next;

  // Remainder carries one extra bit so the doubled value never loses its MSB.
  logic [DW:0]     r_rem;
  logic [DW-1:0]   r_div;
  logic [CW-1:0]   r_cnt;
  logic [QW-1:0]   r_q;
  logic            r_sat;

  logic [DW:0]     w_t;
  logic            w_ge;
  logic [DW:0]     w_rem_next;
  logic [QW-1:0]   w_q_shift;
  logic            w_start;
  logic            w_last;

  // One restoring step: double the remainder, subtract the divisor when it fits.
  always_comb begin
    w_t        = r_rem << 1;
    w_ge       = (w_t >= {1'b0, r_div});
    w_rem_next = w_ge ? (w_t - {1'b0, r_div}) : w_t;
    w_q_shift  = (r_q << 1) | QW'(w_ge);
    w_start    = (r_state == IDLE) && sample;
    w_last     = (r_state == CALC) && (r_cnt == LAST_IDX);
  end

  // State register.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: a request in IDLE starts a conversion, the last quotient bit ends it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (sample) w_next = CALC;
      CALC: if (r_cnt == LAST_IDX) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture and per-bit iteration; operands are frozen for the whole conversion.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_rem <= '0;
      r_div <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_sat <= 1'b0;
    end else if (w_start) begin
      r_rem <= {1'b0, count};
      r_div <= dsor;
      r_cnt <= '0;
      r_q   <= '0;
      // A ratio of 1 or more (including a zero divisor) cannot be shown as a fraction.
      r_sat <= (count >= dsor);
    end else if (r_state == CALC) begin
      r_rem <= w_rem_next;
      r_q   <= w_q_shift;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Result register and done strobe: Q_out only ever changes on the final iteration edge.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      Q_out <= '0;
      done  <= 1'b0;
    end else begin
      done <= w_last;
      if (w_last) begin
        Q_out <= r_sat ? {QW{1'b1}} : w_q_shift;
      end
    end
  end

endmodule

// File: tb/tb_seqdiv_frac.sv
// tb/tb_seqdiv_frac.sv - self-checking bench for seqdiv_frac
module tb_seqdiv_frac;
  localparam int DW = 19;
  localparam int QW = 8;

  logic          clk = 1'b0;
  logic          RST = 1'b0;
  logic          sample = 1'b0;
  logic [DW-1:0] count = '0;
  logic [DW-1:0] dsor = '0;
  logic [QW-1:0] Q_out;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  seqdiv_frac #(.DW(DW), .QW(QW)) dut (
    .clk(clk),
    .RST(RST),
    .sample(sample),
    .count(count),
    .dsor(dsor),
    .Q_out(Q_out),
    .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Ratio as the plain arithmetic definition: fraction of 256, saturating at 255.
  function automatic logic [7:0] ref_ratio(input longint c, input longint d);
    if (c >= d) return 8'hFF;
    return 8'((c * 256) / d);
  endfunction

  // Starts one conversion and watches 20 cycles for done pulses.
  // Called and returns at posedge+1; poke re-requests and alters operands mid-conversion.
  task automatic run_conv(input logic [DW-1:0] c, input logic [DW-1:0] d, input bit poke,
                          output logic [7:0] q, output int lat, output int pulses);
    count  = c;
    dsor   = d;
    sample = 1'b1;
    @(posedge clk); #1;
    sample = 1'b0;
    lat    = -1;
    pulses = 0;
    q      = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          q   = Q_out;
        end
      end
      if (poke && k == 3) begin
        count  = ~c;
        dsor   = d >> 1;
        sample = 1'b1;
      end
      if (poke && k == 4) sample = 1'b0;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    n_tests++;
    if (Q_out !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_q: got %0d, expected 0", Q_out);
    end
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got %b, expected 0", done);
    end
    repeat (2) @(posedge clk);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_directed();
    logic [DW-1:0] tc [6];
    logic [DW-1:0] td [6];
    logic [7:0]    te [6];
    logic [7:0]    q;
    int            lat;
    int            pulses;
    int            bad;
    tc = '{19'd137260, 19'd37560, 19'd1, 19'd0, 19'd5000, 19'd100};
    td = '{19'd152890, 19'd302791, 19'd2, 19'd7, 19'd5000, 19'd0};
    te = '{8'd229, 8'd31, 8'd128, 8'd0, 8'd255, 8'd255};
    for (int i = 0; i < 6; i++) begin
      run_conv(tc[i], td[i], 1'b0, q, lat, pulses);
      n_tests++;
      if (q !== te[i]) begin
        n_fail++;
        $display("FAIL directed_q[%0d]: got %0d, expected %0d", i, q, te[i]);
      end
      n_tests++;
      if (lat != 8 || pulses != 1) begin
        n_fail++;
        $display("FAIL directed_timing[%0d]: latency %0d pulses %0d, expected latency 8 pulses 1", i, lat, pulses);
      end
      if (i == 0) begin
        bad = 0;
        for (int k = 0; k < 35; k++) begin
          @(posedge clk); #1;
          if (Q_out !== 8'd229 || done !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
          n_fail++;
          $display("FAIL hold_229: %0d cycles deviated, expected Q_out 229 and done 0 throughout", bad);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] c;
    logic [DW-1:0] d;
    logic [7:0]    q;
    logic [7:0]    exp_q;
    int            lat;
    int            pulses;
    int            dv;
    for (int i = 0; i < 40; i++) begin
      dv = int'($urandom_range(1, (1 << DW) - 1));
      d  = DW'(dv);
      if (i % 7 == 3) begin
        d = '0;
        c = DW'($urandom_range(0, (1 << DW) - 1));
      end else if (i % 5 == 0) begin
        c = DW'($urandom_range(dv, (1 << DW) - 1));
      end else begin
        c = DW'($urandom_range(0, dv - 1));
      end
      exp_q = ref_ratio(longint'(c), longint'(d));
      run_conv(c, d, 1'b0, q, lat, pulses);
      n_tests++;
      if (q !== exp_q || lat != 8 || pulses != 1) begin
        n_fail++;
        $display("FAIL random[%0d] c=%0d d=%0d: got q %0d lat %0d pulses %0d, expected q %0d lat 8 pulses 1",
                 i, c, d, q, lat, pulses, exp_q);
      end
    end
  endtask

  task automatic test_busy();
    logic [7:0] q;
    int         lat;
    int         pulses;
    run_conv(19'd200000, 19'd400000, 1'b1, q, lat, pulses);
    n_tests++;
    if (q !== 8'd128) begin
      n_fail++;
      $display("FAIL busy_q: got %0d, expected 128", q);
    end
    n_tests++;
    if (lat != 8 || pulses != 1) begin
      n_fail++;
      $display("FAIL busy_timing: latency %0d pulses %0d, expected latency 8 pulses 1", lat, pulses);
    end
  endtask

  task automatic test_back_to_back();
    int done_at[$];
    int bad_q;
    done_at.delete();
    bad_q  = 0;
    count  = 19'd3;
    dsor   = 19'd10;
    sample = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        done_at.push_back(k);
        if (Q_out !== 8'd76) bad_q++;
      end
      if (k == 30) sample = 1'b0;
    end
    n_tests++;
    if (done_at.size() != 4) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d done pulses, expected 4", done_at.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (done_at[i] != 8 + 9 * i) begin
          n_fail++;
          $display("FAIL b2b_spacing[%0d]: done at cycle %0d, expected %0d", i, done_at[i], 8 + 9 * i);
        end
      end
    end
    n_tests++;
    if (bad_q != 0) begin
      n_fail++;
      $display("FAIL b2b_q: %0d pulses with wrong Q_out, expected 76 each time", bad_q);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q;
    int         lat;
    int         pulses;
    int         seen;
    count  = 19'd1;
    dsor   = 19'd3;
    sample = 1'b1;
    @(posedge clk); #1;
    sample = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    RST = 1'b1;
    #1;
    n_tests++;
    if (Q_out !== 8'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async: Q_out %0d done %b, expected 0 and 0", Q_out, done);
    end
    @(posedge clk); #1;
    RST  = 1'b0;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0 || Q_out !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_abort: %0d done pulses Q_out %0d, expected 0 pulses and 0", seen, Q_out);
    end
    run_conv(19'd1, 19'd3, 1'b0, q, lat, pulses);
    n_tests++;
    if (q !== ref_ratio(64'd1, 64'd3) || lat != 8 || pulses != 1) begin
      n_fail++;
      $display("FAIL midreset_recover: got q %0d lat %0d pulses %0d, expected q 85 lat 8 pulses 1", q, lat, pulses);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
